// File: rtl/instr_fetch_mem_if.sv
// Fetch-side bus of the instruction memory: PC request, decode response,
// flush and program-load strobes.
interface instr_fetch_mem_if #(
   parameter int unsigned DATA_W = 32
);
   logic              req_valid;
   logic [31:0]       req_addr;
   logic              req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_instr;
   logic [31:0]       rsp_addr;
   logic              rsp_err;
   logic              flush;
   logic              load_we;
   logic [31:0]       load_addr;
   logic [DATA_W-1:0] load_data;

   modport master (
      output req_valid, req_addr, rsp_ready, flush, load_we, load_addr, load_data,
      input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, flush, load_we, load_addr, load_data,
      output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
   );
endinterface

// File: rtl/instr_fetch_mem.sv
// Synchronous-read instruction memory with one in-flight read stage and a response FIFO.
// Optional IMEM_BOUNDS_CHECK_EN: out-of-range fetches return NOP with rsp_err, out-of-range loads dropped.
module instr_fetch_mem #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic               clk,
   input logic               rst,
   instr_fetch_mem_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned WORDS = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q      [WORDS];
   logic [DATA_W-1:0] fifo_data_q[FIFO_DEPTH];
   logic [31:0]       fifo_addr_q[FIFO_DEPTH];
   logic              fifo_err_q [FIFO_DEPTH];

   logic [DATA_W-1:0] inf_data_q;
   logic [31:0]       inf_addr_q;
   logic              inf_err_q;

   logic              inf_vld_q, inf_vld_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  occ_q, occ_d;

   logic [ADDR_W-1:0] req_idx_c;
   logic [ADDR_W-1:0] load_idx_c;
   logic              req_oob_c;
   logic              load_en_c;
   logic              unused_addr_c;
   logic              rsp_valid_c;
   logic              req_ready_c;
   logic              accept_c;
   logic              pop_c;
   logic              push_c;

   assign req_idx_c  = bus.req_addr[ADDR_W+1:2];
   assign load_idx_c = bus.load_addr[ADDR_W+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
   assign req_oob_c     = |bus.req_addr[31:ADDR_W+2];
   assign load_en_c     = bus.load_we && !(|bus.load_addr[31:ADDR_W+2]);
   assign unused_addr_c = ^{bus.req_addr[1:0], bus.load_addr[1:0]};
`else
   // Upper address bits alias onto the array.
   assign req_oob_c     = 1'b0;
   assign load_en_c     = bus.load_we;
   assign unused_addr_c = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0],
                            bus.load_addr[31:ADDR_W+2], bus.load_addr[1:0]};
`endif

   // Handshake decode; occ counts FIFO entries plus the in-flight read.
   assign rsp_valid_c = !rst && (cnt_q != '0);
   assign pop_c       = rsp_valid_c && bus.rsp_ready && !bus.flush;
   assign push_c      = inf_vld_q && !bus.flush;
   assign req_ready_c = !rst && !bus.flush && !bus.load_we &&
                        ((occ_q != FULL_CNT) || pop_c);
   assign accept_c    = bus.req_valid && req_ready_c;

   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = rsp_valid_c;
   assign bus.rsp_instr = rsp_valid_c ? fifo_data_q[rd_ptr_q] : '0;
   assign bus.rsp_addr  = rsp_valid_c ? fifo_addr_q[rd_ptr_q] : '0;
   assign bus.rsp_err   = rsp_valid_c ? fifo_err_q[rd_ptr_q]  : 1'b0;

   always_comb begin
      inf_vld_d = accept_c;
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_c);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop_c);
      cnt_d     = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      occ_d     = occ_q + CNT_W'(accept_c) - CNT_W'(pop_c);
      if (bus.flush) begin
         inf_vld_d = 1'b0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         cnt_d     = '0;
         occ_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inf_vld_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         occ_q     <= '0;
      end else begin
         inf_vld_q <= inf_vld_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         occ_q     <= occ_d;
      end
   end

   // Payload storage carries no reset; its validity is tracked by the counters above.
   always_ff @(posedge clk) begin
      if (load_en_c) begin
         mem_q[load_idx_c] <= bus.load_data;
      end
      if (accept_c) begin
         inf_data_q <= req_oob_c ? '0 : mem_q[req_idx_c];
         inf_addr_q <= bus.req_addr;
         inf_err_q  <= req_oob_c;
      end
      if (push_c) begin
         fifo_data_q[wr_ptr_q] <= inf_data_q;
         fifo_addr_q[wr_ptr_q] <= inf_addr_q;
         fifo_err_q[wr_ptr_q]  <= inf_err_q;
      end
   end
endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised, synchronous-read instruction memory with a PC-side valid/ready request port, a buffered response FIFO and a program-load write port. Sits between the PC/fetch stage and decode. The fetch stage can issue one request per cycle, and decode can stall without losing instructions. Flush on branch/jump discards buffered and in-flight fetches.

## Interface
Parameters:
- ADDR_W, 8: word-index width; memory holds 2^ADDR_W words.
- DATA_W, 32: instruction width.
- FIFO_DEPTH, 4: response buffer entries; must be a power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address from PC.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- rsp_valid  out  1  FIFO head holds an instruction.
- rsp_ready  in  1  decode consumes head when high with rsp_valid.
- rsp_instr  out  DATA_W  instruction at FIFO head.
- rsp_addr  out  32  byte address of rsp_instr.
- rsp_err  out  1  head entry out of range (bounds check only; else tied 0).
- flush  in  1  discard all buffered and in-flight fetches.
- load_we  in  1  program-load write strobe.
- load_addr  in  32  load byte address.
- load_data  in  DATA_W  load word.

## Operation
- Word index = addr[ADDR_W+1:2]; addr[1:0] ignored.
- Storage is a single-port array of 2^ADDR_W × DATA_W with one access per cycle. Writes take priority over reads.
- Load: load_we=1 writes load_data at the word index on that edge. req_ready=0 in any cycle with load_we=1.
- Request accept: req_valid && req_ready.
  - On accept, the array is read on that edge into an in-flight stage (valid bit, data, address).
  - The stage is pushed into the FIFO on the next edge.
- Occupancy counter `occ` = FIFO entries + in-flight (0..FIFO_DEPTH).
  - req_ready = !rst_state && !flush && !load_we && (occ < FIFO_DEPTH), or (occ == FIFO_DEPTH && pop this cycle).
  - Each accept increments occ, each pop decrements it, and both in the same cycle leave it unchanged.
- Pop: rsp_valid && rsp_ready advances the read pointer.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. full/empty are derived from a separate entry count.
- Flush (highest priority, synchronous):
  - empties the FIFO, clears the in-flight valid bit and sets occ=0 on that edge;
  - req_ready=0 and no pop occurs during the flush cycle;
  - rsp_valid=0 on the following cycle.
- Memory contents are not altered by reset or flush.

## Timing
- Reset (async assert, sync-to-edge release): rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0, req_ready=0 while rst high, FIFO empty, occ=0.
- Latency: request accepted at edge N with an empty FIFO → rsp_valid=1 after edge N+1. There is no combinational bypass.
- Throughput: one accept and one pop per cycle sustained when rsp_ready=1.
- Back-to-back accepts with rsp_ready=0 fill exactly FIFO_DEPTH entries, then req_ready=0.
- Full + pop in the same cycle: a new accept is allowed and occ is unchanged.
- Load and request in the same cycle: the load is performed and the request is not accepted. The fetch side must hold req_valid/req_addr.
- Load to address X followed by a request to X on the next cycle returns the new word.
- Reset mid-operation: all buffered and in-flight entries are lost and no response is produced for them.

## Configuration
- IMEM_BOUNDS_CHECK_EN defined:
  - a request with req_addr[31:ADDR_W+2] ≠ 0 is accepted normally;
  - its response is rsp_instr=0 (NOP) with rsp_err=1;
  - a load with out-of-range address is ignored.
- Undefined: upper address bits are ignored (aliasing) and rsp_err is constant 0.

## Test plan
- Reset, load words 0x00221820 @0x0, 0x00222022 @0x4, 0x00221818 @0x8. Request 0x0, 0x4, 0x8 on consecutive cycles with rsp_ready=1 → the three words appear on three consecutive cycles starting 2 cycles after the first accept, with rsp_addr 0x0/0x4/0x8.
- Backpressure: rsp_ready=0, FIFO_DEPTH=4, continuous requests 0x0..0x14 → exactly 4 accepts, then req_ready=0. Raising rsp_ready drains entries in order with none lost or duplicated.
- Flush with 3 entries buffered and 1 in flight → rsp_valid=0 the next cycle. A request to 0x8 issued afterwards returns 0x00221818 as the sole response.
- Load collision: load_we=1 to 0x4 with data 0xDEADBEEF and req_valid=1 to 0x4 in the same cycle → req_ready=0. The request accepted next cycle returns 0xDEADBEEF.
- Async reset asserted mid-stream with 2 entries buffered → rsp_valid falls immediately without waiting for an edge. After release, no stale response appears.
- With IMEM_BOUNDS_CHECK_EN and ADDR_W=8: request 0x400 → rsp_instr=0, rsp_err=1. Without the macro, the same request returns the word at 0x0 with rsp_err=0.
